// File: rtl/uart_controller.sv
`default_nettype none
// ============================================================================
// uart_controller : synchronises four player inputs and transmits
// {HEADER, state} as an 8N1 UART byte whenever the state changes.
// Revision: 1.0
// ============================================================================
module uart_controller #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [3:0] HEADER       = 4'hA
) (
  input  logic clk_in,
  input  logic rst,
  input  logic up,
  input  logic down,
  input  logic fire,
  input  logic proj,
  output logic tx
);

  localparam int             BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [3:0]        sync_meta;
  logic [3:0]        sync_state;
  logic [3:0]        last_sent;
  logic [1:0]        fsm;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              bit_done;

  assign bit_done = (baud == BAUD_LAST);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_meta  <= 4'b0000;
      sync_state <= 4'b0000;
      last_sent  <= 4'b0000;
      fsm        <= IDLE;
      baud       <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      tx         <= 1'b1;
    end else begin
      sync_meta  <= {proj, fire, down, up};
      sync_state <= sync_meta;

      case (fsm)
        IDLE: begin
          tx      <= 1'b1;
          baud    <= '0;
          bit_cnt <= 3'd0;
          // Start bit is driven on the same edge the byte is latched.
          if (sync_state != last_sent) begin
            shift     <= {HEADER, sync_state};
            last_sent <= sync_state;
            fsm       <= START;
            tx        <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            baud  <= '0;
            fsm   <= DATA;
            tx    <= shift[0];
            shift <= {1'b0, shift[7:1]};
          end else begin
            baud <= baud + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              fsm <= STOP;
              tx  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        STOP: begin
          tx <= 1'b1;
          if (bit_done) begin
            baud <= '0;
            fsm  <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end

        default: begin
          fsm <= IDLE;
          tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_controller.sv
`default_nettype none
// ============================================================================
// tb_uart_controller : randomized self-checking bench; a frame-level model
// predicts which bytes appear on tx and every frame is checked cycle by cycle.
// Revision: 1.0
// ============================================================================
module tb_uart_controller;

  localparam int         CPB = 4;
  localparam logic [3:0] HDR = 4'hA;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic up     = 1'b0;
  logic down   = 1'b0;
  logic fire   = 1'b0;
  logic proj   = 1'b0;
  logic tx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_last;  // model of the nibble carried by the last frame

  uart_controller #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (HDR)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .up    (up),
    .down  (down),
    .fire  (fire),
    .proj  (proj),
    .tx    (tx)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_in(input logic [3:0] s);
    @(negedge clk_in);
    {proj, fire, down, up} = s;
  endtask

  task automatic wait_start(output bit ok);
    int waited = 0;
    while (tx !== 1'b0 && waited < 200) begin
      tick();
      waited++;
    end
    ok = (tx === 1'b0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  // Checks one whole frame: every cycle against the ideal waveform, plus
  // start/data/stop decoded at bit centres. Optionally changes inputs mid-frame.
  task automatic expect_frame(input string tag, input logic [7:0] eb,
                              input bit do_mid, input logic [3:0] mid_a,
                              input logic [3:0] mid_b);
    bit         ok;
    int         errs = 0;
    logic [7:0] rx = 8'h00;
    logic       start_s = 1'b1;
    logic       stop_s  = 1'b0;
    logic       expb;
    int         idx;
    wait_start(ok);
    check({tag, "_start_seen"}, {31'd0, ok}, 1);
    if (!ok) return;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k > 0) tick();
      idx = k / CPB;
      if (idx == 0)      expb = 1'b0;
      else if (idx == 9) expb = 1'b1;
      else               expb = eb[idx-1];
      if (tx !== expb) errs++;
      if (k % CPB == 2) begin
        if (idx == 0)      start_s = tx;
        else if (idx == 9) stop_s = tx;
        else               rx[idx-1] = tx;
      end
      if (do_mid && k == 10) {proj, fire, down, up} = mid_a;
      if (do_mid && k == 20) {proj, fire, down, up} = mid_b;
    end
    check({tag, "_shape"}, errs, 0);
    check({tag, "_startbit"}, {31'd0, start_s}, 0);
    check({tag, "_stopbit"}, {31'd0, stop_s}, 1);
    check({tag, "_data"}, {24'd0, rx}, {24'd0, eb});
    tick();
    check({tag, "_gap"}, {31'd0, tx}, 1);
  endtask

  initial begin
    logic [3:0] s, a, b;
    bit         mid, ok;

    // Reset with all inputs low, then no traffic.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_tx", {31'd0, tx}, 1);
    end
    @(negedge clk_in);
    rst    = 1'b0;
    m_last = 4'b0000;
    expect_quiet("idle_after_reset", 50);

    // Latency: input changed before edge N gives start bit at edge N+2.
    set_in(4'b0001);
    tick();
    check("lat_edge_n", {31'd0, tx}, 1);
    tick();
    check("lat_edge_n1", {31'd0, tx}, 1);
    tick();
    check("lat_edge_n2", {31'd0, tx}, 0);
    expect_frame("up_a1", 8'hA1, 1'b0, 4'b0, 4'b0);
    m_last = 4'b0001;
    expect_quiet("after_a1", 30);

    // fire+proj held constant: exactly one frame.
    set_in(4'b1100);
    expect_frame("fp_ac", 8'hAC, 1'b0, 4'b0, 4'b0);
    m_last = 4'b1100;
    expect_quiet("after_ac", 60);

    // down toggled 1->0->1 inside a frame: frame unchanged, nothing follows.
    set_in(4'b1110);
    expect_frame("toggle", {HDR, 4'b1110}, 1'b1, 4'b1100, 4'b1110);
    m_last = 4'b1110;
    expect_quiet("after_toggle", 60);

    // Randomized state changes, some with mid-frame activity.
    for (int it = 0; it < 20; it++) begin
      s   = 4'($urandom_range(0, 15));
      mid = 1'($urandom_range(0, 1));
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      set_in(s);
      if (s != m_last) begin
        expect_frame("rnd", {HDR, s}, mid, a, b);
        m_last = s;
        if (mid && b != m_last) begin
          expect_frame("rnd_newest", {HDR, b}, 1'b0, 4'b0, 4'b0);
          m_last = b;
        end
      end
      expect_quiet("rnd_quiet", 60);
    end

    // Reset mid-frame aborts; unchanged nonzero inputs resend a full frame.
    s = (m_last != 4'b1011) ? 4'b1011 : 4'b0111;
    set_in(s);
    wait_start(ok);
    check("rstmid_start_seen", {31'd0, ok}, 1);
    for (int k = 0; k < 15; k++) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_tx_high", {31'd0, tx}, 1);
    end
    rst    = 1'b0;
    m_last = 4'b0000;
    expect_frame("after_rst", {HDR, s}, 1'b0, 4'b0, 4'b0);
    m_last = s;
    expect_quiet("final_quiet", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
